// File: rtl/ex_alu_pkg.sv
// Op-code definitions shared by the EX-stage ALU/multiplier unit and its multiplier core.
// The multiplier is built only when the macro EX_MUL_EN is defined.
package ex_alu_pkg;

    localparam logic [3:0] ALU_OP_ADD    = 4'h0;
    localparam logic [3:0] ALU_OP_SUB    = 4'h1;
    localparam logic [3:0] ALU_OP_SLL    = 4'h2;
    localparam logic [3:0] ALU_OP_SLT    = 4'h3;
    localparam logic [3:0] ALU_OP_SLTU   = 4'h4;
    localparam logic [3:0] ALU_OP_XOR    = 4'h5;
    localparam logic [3:0] ALU_OP_SRL    = 4'h6;
    localparam logic [3:0] ALU_OP_SRA    = 4'h7;
    localparam logic [3:0] ALU_OP_OR     = 4'h8;
    localparam logic [3:0] ALU_OP_AND    = 4'h9;
    localparam logic [3:0] ALU_OP_PASS_B = 4'hA;
    localparam logic [3:0] ALU_OP_MUL    = 4'hB;
    localparam logic [3:0] ALU_OP_MULH   = 4'hC;
    localparam logic [3:0] ALU_OP_MULHSU = 4'hD;
    localparam logic [3:0] ALU_OP_MULHU  = 4'hE;
    localparam logic [3:0] ALU_OP_RSVD   = 4'hF;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_MULH) ||
               (op == ALU_OP_MULHSU) || (op == ALU_OP_MULHU);
    endfunction

endpackage

// File: rtl/ex_mul_core.sv
// Combinational 32x32 multiplier: returns the low or high product word selected by the op code,
// and 0 for any non-multiply code.
module ex_mul_core
    import ex_alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] product
);

    logic               a_signed;
    logic               b_signed;
    logic signed [32:0] a_ext;
    logic signed [32:0] b_ext;
    logic signed [65:0] prod_full;
    logic        [63:0] prod;
    logic               unused_prod_top;

    assign a_signed = (op == ALU_OP_MULH) || (op == ALU_OP_MULHSU);
    assign b_signed = (op == ALU_OP_MULH);

    // One 33x33 signed multiply covers all three signedness combinations.
    assign a_ext     = {a_signed & src_a[31], src_a};
    assign b_ext     = {b_signed & src_b[31], src_b};
    assign prod_full = a_ext * b_ext;
    assign prod      = prod_full[63:0];
    assign unused_prod_top = ^prod_full[65:64];

    always_comb begin
        product = '0;
        case (op)
            ALU_OP_MUL:    product = prod[31:0];
            ALU_OP_MULH,
            ALU_OP_MULHSU,
            ALU_OP_MULHU:  product = prod[63:32];
            default:       product = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_mul_unit.sv
// EX-stage RV32I ALU plus optional RV32M multiplier with a one-cycle registered result.
// Define EX_MUL_EN to build the multiplier; otherwise multiply codes return 0 like the reserved code.
module ex_alu_mul_unit
    import ex_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            valid_o
);

    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] final_result;
    logic [4:0]      shamt;
    logic [XLEN-1:0] result_reg;
    logic            zero_reg;
    logic            valid_reg;

    assign shamt = operand_b_i[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_op_i)
            ALU_OP_ADD:    alu_result = operand_a_i + operand_b_i;
            ALU_OP_SUB:    alu_result = operand_a_i - operand_b_i;
            ALU_OP_SLL:    alu_result = operand_a_i << shamt;
            ALU_OP_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
            ALU_OP_SLTU:   alu_result = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
            ALU_OP_XOR:    alu_result = operand_a_i ^ operand_b_i;
            ALU_OP_SRL:    alu_result = operand_a_i >> shamt;
            ALU_OP_SRA:    alu_result = $unsigned($signed(operand_a_i) >>> shamt);
            ALU_OP_OR:     alu_result = operand_a_i | operand_b_i;
            ALU_OP_AND:    alu_result = operand_a_i & operand_b_i;
            ALU_OP_PASS_B: alu_result = operand_b_i;
            default:       alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic [XLEN-1:0] mul_result;

    // Multiplier B is always rs2, never the immediate carried on operand_b_i.
    ex_mul_core u_mul_core (
        .op      (alu_op_i),
        .src_a   (operand_a_i),
        .src_b   (rs2_data_i),
        .product (mul_result)
    );

    assign final_result = is_mul_op(alu_op_i) ? mul_result : alu_result;
`else
    logic unused_rs2;

    assign unused_rs2   = ^rs2_data_i;
    assign final_result = alu_result;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= valid_i;
            if (valid_i) begin
                result_reg <= final_result;
                zero_reg   <= (final_result == '0);
            end
        end
    end

    assign result_o = result_reg;
    assign zero_o   = zero_reg;
    assign valid_o  = valid_reg;

endmodule

// File: tb/tb_ex_alu_mul_unit.sv
// Self-checking bench for ex_alu_mul_unit: directed vectors plus randomized ops against a
// behavioural model; follows EX_MUL_EN to decide whether multiply codes are live.
module tb_ex_alu_mul_unit;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  alu_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [31:0] rs2_data_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        valid_o;

    int total;
    int bad;

    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_valid;

    ex_alu_mul_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .alu_op_i    (alu_op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .rs2_data_i  (rs2_data_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] r);
        logic [63:0] ua;
        logic [63:0] ur;
        logic [63:0] sa;
        logic [63:0] sr;
        logic [63:0] p;
        logic [4:0]  sh;
        ua = {32'b0, a};
        ur = {32'b0, r};
        sa = {{32{a[31]}}, a};
        sr = {{32{r[31]}}, r};
        sh = b[4:0];
        p  = '0;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a << sh;
            4'h3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h4: return (a < b) ? 32'd1 : 32'd0;
            4'h5: return a ^ b;
            4'h6: return a >> sh;
            4'h7: begin p = sa >> sh; return p[31:0]; end
            4'h8: return a | b;
            4'h9: return a & b;
            4'hA: return b;
            4'hB: begin p = ua * ur; return MUL_EN ? p[31:0] : 32'd0; end
            4'hC: begin p = sa * sr; return MUL_EN ? p[63:32] : 32'd0; end
            4'hD: begin p = sa * ur; return MUL_EN ? p[63:32] : 32'd0; end
            4'hE: begin p = ua * ur; return MUL_EN ? p[63:32] : 32'd0; end
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs, update the scoreboard, and land 1 time unit after the edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r);
        valid_i     = v;
        alu_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        rs2_data_i  = r;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            exp_res  = model(op, a, b, r);
            exp_zero = (exp_res == 32'd0);
        end
        $display("txn v=%b op=%h a=%h b=%h rs2=%h -> res=%h zero=%b valid=%b",
                 v, op, a, b, r, result_o, zero_o, valid_o);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (result_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_result got=%h want=%h", result_o, 32'd0);
        end
        total++;
        if (zero_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_zero got=%b want=0", zero_o);
        end
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        total++;
        if ({valid_o, zero_o, result_o} !== 34'd0) begin
            bad++;
            $display("FAIL reset_idle got=%b/%b/%h want=0/0/0", valid_o, zero_o, result_o);
        end
    endtask

    task automatic test_directed;
        logic [3:0]  ops [12];
        logic [31:0] av  [12];
        logic [31:0] bv  [12];
        logic [31:0] rv  [12];
        logic [31:0] ev  [12];
        ops = '{4'h1, 4'h7, 4'h3, 4'h4, 4'hB, 4'hE, 4'hC, 4'hD, 4'hB, 4'h0, 4'hF, 4'h0};
        av  = '{32'hC41F1EFB, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h7, 32'h12345678, 32'h1};
        bv  = '{32'h6A9E3146, 32'h24, 32'h1, 32'h1, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h5, 32'h5, 32'h9ABCDEF0, 32'hFFFFFFFF};
        rv  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 32'h3, 32'h55, 32'h0};
        ev  = '{32'h5980EDB5, 32'hF8000000, 32'h1, 32'h0,
                MUL_EN ? 32'h00000001 : 32'h0, MUL_EN ? 32'hFFFFFFFE : 32'h0,
                32'h0, MUL_EN ? 32'hFFFFFFFF : 32'h0, MUL_EN ? 32'h15 : 32'h0,
                32'hC, 32'h0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            step(1'b1, ops[i], av[i], bv[i], rv[i]);
            total++;
            if ({valid_o, zero_o, result_o} !== {1'b1, ev[i] == 32'd0, ev[i]}) begin
                bad++;
                $display("FAIL directed_%0d op=%h got=%b/%b/%h want=1/%b/%h",
                         i, ops[i], valid_o, zero_o, result_o, ev[i] == 32'd0, ev[i]);
            end
        end
    endtask

    task automatic test_hold;
        step(1'b1, 4'h0, 32'h1, 32'hFFFFFFFF, 32'h0);
        total++;
        if ({valid_o, zero_o, result_o} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL hold_load got=%b/%b/%h want=1/1/0", valid_o, zero_o, result_o);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'hA, $urandom, $urandom, $urandom);
            total++;
            if ({valid_o, zero_o, result_o} !== {1'b0, 1'b1, 32'h0}) begin
                bad++;
                $display("FAIL hold_idle_%0d got=%b/%b/%h want=0/1/0", i, valid_o, zero_o, result_o);
            end
        end
    endtask

    task automatic test_random;
        logic        v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 150; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            step(v, op, a, b, $urandom);
            total++;
            if ({valid_o, zero_o, result_o} !== {exp_valid, exp_zero, exp_res}) begin
                bad++;
                $display("FAIL random_%0d op=%h got=%b/%b/%h want=%b/%b/%h",
                         i, op, valid_o, zero_o, result_o, exp_valid, exp_zero, exp_res);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom);
            total++;
            if ({valid_o, zero_o, result_o} !== {1'b1, exp_zero, exp_res}) begin
                bad++;
                $display("FAIL b2b_%0d got=%b/%b/%h want=1/%b/%h",
                         i, valid_o, zero_o, result_o, exp_zero, exp_res);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 4'h0, 32'h5, 32'h6, 32'h0);
        valid_i     = 1'b1;
        alu_op_i    = 4'hA;
        operand_b_i = 32'h1234;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({valid_o, zero_o, result_o} !== 34'd0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b/%h want=0/0/0", valid_o, zero_o, result_o);
        end
        @(posedge clk);
        #1;
        total++;
        if ({valid_o, zero_o, result_o} !== 34'd0) begin
            bad++;
            $display("FAIL reset_discard got=%b/%b/%h want=0/0/0", valid_o, zero_o, result_o);
        end
        valid_i = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_res   = 32'd0;
        exp_zero  = 1'b0;
        exp_valid = 1'b0;
        step(1'b1, 4'hA, 32'h0, 32'hABCD0000, 32'h0);
        total++;
        if ({valid_o, zero_o, result_o} !== {1'b1, 1'b0, 32'hABCD0000}) begin
            bad++;
            $display("FAIL post_reset_pass got=%b/%b/%h want=1/0/abcd0000", valid_o, zero_o, result_o);
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        valid_i     = 1'b0;
        alu_op_i    = 4'h0;
        operand_a_i = 32'h0;
        operand_b_i = 32'h0;
        rs2_data_i  = 32'h0;
        total       = 0;
        bad         = 0;
        exp_res     = 32'd0;
        exp_zero    = 1'b0;
        exp_valid   = 1'b0;

        test_reset;
        test_directed;
        test_hold;
        test_random;
        test_back_to_back;
        test_reset_mid;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
